// File: rtl/fifo_param_if.sv
// fifo_param_if
// Bundles the request side and the status/read side of one fifo_param
// channel so a producer/consumer pair can be wired with a single port.
//   master : the stage that issues push/pop, write data, thresholds and
//            error clear; it observes the read port and all status flags.
//   slave  : the FIFO itself.
// DATA_SIZE sets the word width and ADDR_SIZE the depth (2**ADDR_SIZE).
// CNT_SIZE is derived and sizes the count and threshold fields.
interface fifo_param_if #(
    parameter int DATA_SIZE = 6,
    parameter int ADDR_SIZE = 4
);
    localparam int CNT_SIZE = ADDR_SIZE + 1;

    logic                 push;
    logic                 pop;
    logic [DATA_SIZE-1:0] data_in;
    logic [CNT_SIZE-1:0]  afull_th;
    logic [CNT_SIZE-1:0]  aempty_th;
    logic                 err_clr;

    logic [DATA_SIZE-1:0] data_out;
    logic                 data_valid;
    logic [CNT_SIZE-1:0]  data_count;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 almost_full;
    logic                 almost_empty;
    logic                 fifo_pause;
    logic                 err_overflow;
    logic                 err_underflow;
    logic                 fifo_error;

    modport master (
        output push, pop, data_in, afull_th, aempty_th, err_clr,
        input  data_out, data_valid, data_count, fifo_empty, fifo_full,
               almost_full, almost_empty, fifo_pause,
               err_overflow, err_underflow, fifo_error
    );

    modport slave (
        input  push, pop, data_in, afull_th, aempty_th, err_clr,
        output data_out, data_valid, data_count, fifo_empty, fifo_full,
               almost_full, almost_empty, fifo_pause,
               err_overflow, err_underflow, fifo_error
    );
endinterface

// File: rtl/fifo_param.sv
// fifo_param
// Parametrised synchronous FIFO with registered read port, occupancy count,
// almost-full/almost-empty flags, hysteretic pause and sticky errors.
// Ports:
//   clk      : single clock, everything updates on the rising edge
//   reset_L  : synchronous active-low reset
//   bus      : fifo_param_if slave modport carrying push/pop/data_in,
//              thresholds, err_clr and all read/status outputs
module fifo_param #(
    parameter int DATA_SIZE = 6,
    parameter int ADDR_SIZE = 4
) (
    input logic          clk,
    input logic          reset_L,
    fifo_param_if.slave  bus
);
    localparam int CNT_SIZE = ADDR_SIZE + 1;
    localparam int DEPTH    = 1 << ADDR_SIZE;
    localparam logic [CNT_SIZE-1:0] DEPTH_CNT = CNT_SIZE'(DEPTH);

    // Storage is deliberately left unreset; pointers and count define validity.
    logic [DATA_SIZE-1:0] mem_q [DEPTH];

    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_SIZE-1:0]  count_q, count_d;
    logic [DATA_SIZE-1:0] data_out_q, data_out_d;
    logic                 valid_q, valid_d;
    logic                 pause_q, pause_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;

    logic empty, full, pop_ok, push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_CNT);
    assign pop_ok  = bus.pop & ~empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
    assign push_ok = bus.push & (~full | pop_ok);

    // Next-state for pointers, count, read port, pause and sticky errors.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_SIZE'(1);
        end

        if (pop_ok) begin
            rd_ptr_d   = rd_ptr_q + ADDR_SIZE'(1);
            data_out_d = mem_q[rd_ptr_q];
            valid_d    = 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_SIZE'(1);
            2'b01:   count_d = count_q - CNT_SIZE'(1);
            default: count_d = count_q;
        endcase

        // Set is tested first so misprogrammed thresholds resolve to paused.
        if (count_q >= bus.afull_th) begin
            pause_d = 1'b1;
        end else if (count_q <= bus.aempty_th) begin
            pause_d = 1'b0;
        end else begin
            pause_d = pause_q;
        end

        // A new error in the clearing cycle must not be lost.
        ovf_d = (bus.push & full & ~pop_ok) | (ovf_q & ~bus.err_clr);
        unf_d = (bus.pop & empty)           | (unf_q & ~bus.err_clr);
    end

    // Control and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            pause_q    <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            pause_q    <= pause_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Memory write; requests seen while reset is asserted are dropped.
    always_ff @(posedge clk) begin
        if (reset_L && push_ok) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    assign bus.data_out      = data_out_q;
    assign bus.data_valid    = valid_q;
    assign bus.data_count    = count_q;
    assign bus.fifo_empty    = empty;
    assign bus.fifo_full     = full;
    assign bus.almost_full   = (count_q >= bus.afull_th);
    assign bus.almost_empty  = (count_q <= bus.aempty_th) & ~empty;
    assign bus.fifo_pause    = pause_q;
    assign bus.err_overflow  = ovf_q;
    assign bus.err_underflow = unf_q;
    assign bus.fifo_error    = ovf_q | unf_q;

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param
// Directed, table-driven bench for fifo_param (DATA_SIZE=6, ADDR_SIZE=4).
// A queue of records holds each cycle's inputs and the hand-derived
// expected count, read port, pause and error flags; the status flags are
// decoded from the expected count. Hand-written sequences cover reset in
// mid-operation and misprogrammed thresholds.
module tb_fifo_param;

    typedef struct {
        logic       push;
        logic       pop;
        logic [5:0] din;
        logic       clr;
        logic [4:0] cnt;
        logic       valid;
        logic [5:0] dout;
        logic       pause;
        logic       ovf;
        logic       unf;
    } vec_t;

    logic clk;
    logic reset_L;
    int   checks;
    int   errors;
    int   afullTh;
    int   aemptyTh;
    vec_t vecs[$];

    fifo_param_if #(.DATA_SIZE(6), .ADDR_SIZE(4)) bus ();

    fifo_param #(.DATA_SIZE(6), .ADDR_SIZE(4)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void addVec(input int push, input int pop, input int din,
                                   input int clr, input int cnt, input int valid,
                                   input int dout, input int pause, input int ovf,
                                   input int unf);
        vec_t v;
        v.push  = 1'(push);
        v.pop   = 1'(pop);
        v.din   = 6'(din);
        v.clr   = 1'(clr);
        v.cnt   = 5'(cnt);
        v.valid = 1'(valid);
        v.dout  = 6'(dout);
        v.pause = 1'(pause);
        v.ovf   = 1'(ovf);
        v.unf   = 1'(unf);
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of requests, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic push, input logic pop,
                                 input logic [5:0] din, input logic clr);
        bus.push    = push;
        bus.pop     = pop;
        bus.data_in = din;
        bus.err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        int c;
        c = int'(v.cnt);
        chk("count",        idx, 32'(bus.data_count),    32'(v.cnt));
        chk("valid",        idx, 32'(bus.data_valid),    32'(v.valid));
        chk("dout",         idx, 32'(bus.data_out),      32'(v.dout));
        chk("empty",        idx, 32'(bus.fifo_empty),    32'(c == 0));
        chk("full",         idx, 32'(bus.fifo_full),     32'(c == 16));
        chk("almost_full",  idx, 32'(bus.almost_full),   32'(c >= afullTh));
        chk("almost_empty", idx, 32'(bus.almost_empty),  32'((c <= aemptyTh) && (c != 0)));
        chk("pause",        idx, 32'(bus.fifo_pause),    32'(v.pause));
        chk("overflow",     idx, 32'(bus.err_overflow),  32'(v.ovf));
        chk("underflow",    idx, 32'(bus.err_underflow), 32'(v.unf));
        chk("fifo_error",   idx, 32'(bus.fifo_error),    32'(v.ovf | v.unf));
    endtask

    task automatic stepCheck(input int idx, input int push, input int pop, input int din,
                             input int clr, input int cnt, input int valid,
                             input int dout, input int pause, input int ovf,
                             input int unf);
        vec_t v;
        v.push  = 1'(push);
        v.pop   = 1'(pop);
        v.din   = 6'(din);
        v.clr   = 1'(clr);
        v.cnt   = 5'(cnt);
        v.valid = 1'(valid);
        v.dout  = 6'(dout);
        v.pause = 1'(pause);
        v.ovf   = 1'(ovf);
        v.unf   = 1'(unf);
        applyStimulus(v.push, v.pop, v.din, v.clr);
        checkOutput(idx, v);
    endtask

    initial begin
        vec_t r;
        checks   = 0;
        errors   = 0;
        afullTh  = 12;
        aemptyTh = 3;

        // Fill with 0x01..0x10; pause rises the cycle after count hits 12.
        for (int k = 1; k <= 16; k++)
            addVec(1, 0, k, 0, k, 0, 0, int'(k >= 13), 0, 0);
        // Full: simultaneous push 0x2A and pop, no overflow.
        addVec(1, 1, 'h2A, 0, 16, 1, 'h01, 1, 0, 0);
        // Full: push without pop overflows, count unchanged.
        addVec(1, 0, 'h3F, 0, 16, 0, 'h01, 1, 1, 0);
        addVec(0, 0, 0,    1, 16, 0, 'h01, 1, 0, 0);
        // Overflow in the clearing cycle stays set.
        addVec(1, 0, 'h3E, 1, 16, 0, 'h01, 1, 1, 0);
        addVec(0, 0, 0,    1, 16, 0, 'h01, 1, 0, 0);
        // Drain: 0x02..0x10 then 0x2A; pause clears the cycle after count hits 3.
        for (int j = 1; j <= 16; j++)
            addVec(0, 1, 0, 0, 16 - j, 1, (j <= 15) ? j + 1 : 'h2A, int'(j <= 13), 0, 0);
        // Pop on empty: underflow, read port holds.
        addVec(0, 1, 0, 0, 0, 0, 'h2A, 0, 0, 1);
        addVec(0, 0, 0, 1, 0, 0, 'h2A, 0, 0, 0);
        // Push+pop on empty: push wins, pop rejected and flagged.
        addVec(1, 1, 'h15, 0, 1, 0, 'h2A, 0, 0, 1);
        // Back-to-back at count 1, with error clear.
        addVec(1, 1, 'h16, 1, 1, 1, 'h15, 0, 0, 0);
        addVec(0, 1, 0,    0, 0, 1, 'h16, 0, 0, 0);

        reset_L       = 1'b0;
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.data_in   = '0;
        bus.err_clr   = 1'b0;
        bus.afull_th  = 5'(afullTh);
        bus.aempty_th = 5'(aemptyTh);
        @(posedge clk);
        @(posedge clk);
        #1;
        r = '{push: 0, pop: 0, din: 0, clr: 0, cnt: 0, valid: 0, dout: 0,
              pause: 0, ovf: 0, unf: 0};
        checkOutput(-1, r);
        reset_L = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].push, vecs[i].pop, vecs[i].din, vecs[i].clr);
            checkOutput(i, vecs[i]);
        end

        // Reset during operation with a push request pending.
        stepCheck(100, 0, 1, 0, 0, 0, 0, 'h16, 0, 0, 1);
        for (int k = 0; k < 7; k++)
            stepCheck(101 + k, 1, 0, 'h30 + k, 0, k + 1, 0, 'h16, 0, 0, 1);
        reset_L = 1'b0;
        stepCheck(110, 1, 0, 'h3F, 0, 0, 0, 0, 0, 0, 0);
        reset_L = 1'b1;
        stepCheck(111, 1, 0, 'h0C, 0, 1, 0, 0,    0, 0, 0);
        stepCheck(112, 0, 1, 0,    0, 0, 1, 'h0C, 0, 0, 0);

        // Misprogrammed thresholds (afull <= aempty): set takes priority.
        afullTh       = 2;
        aemptyTh      = 5;
        bus.afull_th  = 5'(afullTh);
        bus.aempty_th = 5'(aemptyTh);
        stepCheck(120, 1, 0, 'h21, 0, 1, 0, 'h0C, 0, 0, 0);
        stepCheck(121, 1, 0, 'h22, 0, 2, 0, 'h0C, 0, 0, 0);
        stepCheck(122, 1, 0, 'h23, 0, 3, 0, 'h0C, 1, 0, 0);
        stepCheck(123, 0, 1, 0,    0, 2, 1, 'h21, 1, 0, 0);
        stepCheck(124, 0, 1, 0,    0, 1, 1, 'h22, 1, 0, 0);
        stepCheck(125, 0, 1, 0,    0, 0, 1, 'h23, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
